// File: rtl/count_seq_checker_pkg.sv
// Shared types and defaults for the counter-sequence checker: state enum,
// default widths and the encoding presented on the debug state port.
package count_seq_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ERR_W = 8;
    localparam int STATE_W   = 2;
    localparam int CNT_W     = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_HUNT    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

    function automatic logic [STATE_W-1:0] encode_state(input state_e s);
        return STATE_W'(s);
    endfunction

endpackage

// File: rtl/count_seq_checker_if.sv
// Sample/flag bundle between a counter stream source and the sequence checker.
interface count_seq_checker_if
    import count_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ERR_W = DEF_ERR_W
);
    logic               enable;
    logic [WIDTH-1:0]   data_in;
    logic               clr_err;
    logic               locked;
    logic               error_pulse;
    logic [ERR_W-1:0]   err_count;
    logic [WIDTH-1:0]   expected;
    logic [STATE_W-1:0] state;

    modport master (
        output enable, data_in, clr_err,
        input  locked, error_pulse, err_count, expected, state
    );

    modport slave (
        input  enable, data_in, clr_err,
        output locked, error_pulse, err_count, expected, state
    );
endinterface

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            count_q <= '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;
endmodule

// File: rtl/count_seq_checker.sv
// Locks onto a +1 counter stream, flags out-of-sequence samples while locked
// and keeps a saturating error count.
module count_seq_checker
    import count_seq_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_W      = DEF_ERR_W
) (
    input logic               clk,
    input logic               reset,
    count_seq_checker_if.slave bus
);
    localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] LOSS_C = CNT_W'(LOSS_COUNT);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   expected_q, expected_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic               locked_q, locked_d;
    logic               error_pulse_q, error_pulse_d;
    logic               err_inc;
    logic               hit;

    assign hit = (bus.data_in == expected_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_HUNT;
            expected_q    <= '0;
            match_cnt_q   <= '0;
            miss_cnt_q    <= '0;
            locked_q      <= 1'b0;
            error_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            expected_q    <= expected_d;
            match_cnt_q   <= match_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            locked_q      <= locked_d;
            error_pulse_q <= error_pulse_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        expected_d    = expected_q;
        match_cnt_d   = match_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        locked_d      = locked_q;
        error_pulse_d = 1'b0;
        err_inc       = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (bus.enable) begin
                    expected_d  = bus.data_in + WIDTH'(1);
                    match_cnt_d = CNT_W'(1);
                    state_d     = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (bus.enable) begin
                    if (hit) begin
                        expected_d  = expected_q + WIDTH'(1);
                        match_cnt_d = match_cnt_q + CNT_W'(1);
                        if (match_cnt_q + CNT_W'(1) == LOCK_C) begin
                            state_d    = ST_LOCKED;
                            locked_d   = 1'b1;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        // Broken run before lock: restart the run from this sample.
                        expected_d  = bus.data_in + WIDTH'(1);
                        match_cnt_d = CNT_W'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (bus.enable) begin
                    expected_d = expected_q + WIDTH'(1);
                    if (hit) begin
                        miss_cnt_d = '0;
                    end else begin
                        // Keep free-running so a single glitch costs one error only.
                        error_pulse_d = 1'b1;
                        err_inc       = 1'b1;
                        miss_cnt_d    = miss_cnt_q + CNT_W'(1);
                        if (miss_cnt_q + CNT_W'(1) == LOSS_C) begin
                            state_d     = ST_HUNT;
                            locked_d    = 1'b0;
                            miss_cnt_d  = '0;
                            match_cnt_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d     = ST_HUNT;
                locked_d    = 1'b0;
                match_cnt_d = '0;
                miss_cnt_d  = '0;
            end
        endcase
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .srst  (reset),
        .inc   (err_inc),
        .clr   (bus.clr_err),
        .count (bus.err_count)
    );

    assign bus.locked      = locked_q;
    assign bus.error_pulse = error_pulse_q;
    assign bus.expected    = expected_q;
    assign bus.state       = encode_state(state_q);
endmodule

// File: tb/tb_count_seq_checker.sv
// Drives directed and random counter streams into two checkers (ERR_W=8 and 2)
// and compares every output each cycle against a behavioural model.
module tb_count_seq_checker;
    localparam int LOCK_COUNT = 4;
    localparam int LOSS_COUNT = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    count_seq_checker_if #(.WIDTH(8), .ERR_W(8)) bus8 ();
    count_seq_checker_if #(.WIDTH(8), .ERR_W(2)) bus2 ();

    count_seq_checker #(.WIDTH(8), .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .ERR_W(8)) dut8 (
        .clk(clk), .reset(reset), .bus(bus8)
    );
    count_seq_checker #(.WIDTH(8), .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    int checks = 0;
    int errors = 0;
    int txn = 0;

    // Reference model: mode 0=hunting, 1=building a run, 2=locked.
    int m_state, m_exp, m_run, m_miss, m_err, m_err2;
    bit m_pulse;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (txn %0d)", tag, got, want, txn);
        end
    endtask

    task automatic model_step(input bit rst, input bit en, input int d, input bit clr);
        if (rst) begin
            m_state = 0; m_exp = 0; m_run = 0; m_miss = 0;
            m_err = 0; m_err2 = 0; m_pulse = 0;
            return;
        end
        m_pulse = 0;
        if (en) begin
            if (m_state == 0) begin
                m_exp = (d + 1) % 256; m_run = 1; m_state = 1;
            end else if (m_state == 1) begin
                if (d == m_exp) begin
                    m_exp = (m_exp + 1) % 256;
                    m_run++;
                    if (m_run == LOCK_COUNT) begin m_state = 2; m_miss = 0; end
                end else begin
                    m_exp = (d + 1) % 256; m_run = 1;
                end
            end else begin
                if (d == m_exp) begin
                    m_miss = 0;
                end else begin
                    m_pulse = 1;
                    if (m_err < 255) m_err++;
                    if (m_err2 < 3) m_err2++;
                    m_miss++;
                end
                m_exp = (m_exp + 1) % 256;
                if (m_miss == LOSS_COUNT) begin m_state = 0; m_miss = 0; m_run = 0; end
            end
        end
        if (clr) begin m_err = 0; m_err2 = 0; end
    endtask

    task automatic cycle(input bit rst, input bit en, input logic [7:0] d, input bit clr);
        reset = rst;
        bus8.enable = en;  bus8.data_in = d;  bus8.clr_err = clr;
        bus2.enable = en;  bus2.data_in = d;  bus2.clr_err = clr;
        @(posedge clk);
        model_step(rst, en, int'(d), clr);
        #1;
        txn++;
        $display("txn %0d rst=%0b en=%0b d=%02h clr=%0b -> st=%0d exp=%02h lk=%0b ep=%0b err=%0d err2=%0d",
                 txn, rst, en, d, clr, bus8.state, bus8.expected, bus8.locked,
                 bus8.error_pulse, bus8.err_count, bus2.err_count);
        check("state",       32'(bus8.state),       32'(m_state));
        check("expected",    32'(bus8.expected),    32'(m_exp));
        check("locked",      32'(bus8.locked),      32'(m_state == 2));
        check("error_pulse", 32'(bus8.error_pulse), 32'(m_pulse));
        check("err_count",   32'(bus8.err_count),   32'(m_err));
        check("err_count_w2",32'(bus2.err_count),   32'(m_err2));
        check("state_w2",    32'(bus2.state),       32'(m_state));
    endtask

    task automatic feed(input logic [7:0] d);
        cycle(1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic lock_at(input logic [7:0] base);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) feed(base + 8'(i));
    endtask

    initial begin
        logic [7:0] src;
        int pulses;

        // Reset state
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        check("rst_state", 32'(bus8.state), 32'd0);
        check("rst_expected", 32'(bus8.expected), 32'd0);

        // Lock-on C5..C8
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        pulses = 0;
        feed(8'hC5); pulses += int'(bus8.error_pulse);
        feed(8'hC6); pulses += int'(bus8.error_pulse);
        feed(8'hC7); pulses += int'(bus8.error_pulse);
        check("not_locked_c7", 32'(bus8.locked), 32'd0);
        feed(8'hC8); pulses += int'(bus8.error_pulse);
        check("lock_c8", 32'(bus8.locked), 32'd1);
        check("lock_exp_c9", 32'(bus8.expected), 32'hC9);
        check("lock_pulses", 32'(pulses), 32'd0);

        // Wrap FD..01
        lock_at(8'hF9);
        pulses = 0;
        feed(8'hFD); feed(8'hFE); pulses += int'(bus8.error_pulse);
        feed(8'hFF); pulses += int'(bus8.error_pulse);
        feed(8'h00); pulses += int'(bus8.error_pulse);
        feed(8'h01); pulses += int'(bus8.error_pulse);
        check("wrap_pulses", 32'(pulses), 32'd0);
        check("wrap_locked", 32'(bus8.locked), 32'd1);
        check("wrap_exp", 32'(bus8.expected), 32'h02);

        // Single glitch
        lock_at(8'h0C);
        feed(8'h10); feed(8'h11);
        check("glitch_pre", 32'(bus8.error_pulse), 32'd0);
        feed(8'h55);
        check("glitch_pulse", 32'(bus8.error_pulse), 32'd1);
        feed(8'h13);
        check("glitch_one_cycle", 32'(bus8.error_pulse), 32'd0);
        feed(8'h14);
        check("glitch_err", 32'(bus8.err_count), 32'd1);
        check("glitch_locked", 32'(bus8.locked), 32'd1);

        // Loss of lock
        lock_at(8'h1C);
        feed(8'h99); feed(8'h99);
        check("loss_still_locked", 32'(bus8.locked), 32'd1);
        feed(8'h99);
        check("loss_err", 32'(bus8.err_count), 32'd3);
        check("loss_unlocked", 32'(bus8.locked), 32'd0);
        check("loss_hunt", 32'(bus8.state), 32'd0);
        feed(8'h40);
        check("reseed_sync", 32'(bus8.state), 32'd1);
        check("reseed_exp", 32'(bus8.expected), 32'h41);

        // Gaps
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        feed(8'hC5);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'($urandom), 1'b0);
        check("gap_exp_hold", 32'(bus8.expected), 32'hC6);
        feed(8'hC6); feed(8'hC7); feed(8'hC8);
        check("gap_lock", 32'(bus8.locked), 32'd1);

        // Sync re-seed
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        feed(8'hC5); feed(8'hC6); feed(8'h07);
        check("sync_reseed_exp", 32'(bus8.expected), 32'h08);
        check("sync_reseed_state", 32'(bus8.state), 32'd1);
        feed(8'h08); feed(8'h09);
        check("reseed_run_short", 32'(bus8.locked), 32'd0);
        feed(8'h0A);
        check("reseed_run_lock", 32'(bus8.locked), 32'd1);

        // Five errors without losing lock, then reset
        lock_at(8'h2C);
        for (int i = 0; i < 5; i++) begin
            feed(8'hAA);
            feed(8'h31 + 8'(2 * i));
        end
        check("err5", 32'(bus8.err_count), 32'd5);
        check("err5_w2_sat", 32'(bus2.err_count), 32'd3);
        check("err5_locked", 32'(bus8.locked), 32'd1);
        cycle(1'b1, 1'b1, 8'hAA, 1'b0);
        check("rst_err", 32'(bus8.err_count), 32'd0);
        check("rst_locked", 32'(bus8.locked), 32'd0);
        check("rst_hunt", 32'(bus8.state), 32'd0);

        // Clear coincident with a mismatch
        lock_at(8'h50);
        feed(8'hEE);
        check("pre_clr_err", 32'(bus8.err_count), 32'd1);
        cycle(1'b0, 1'b1, 8'hEE, 1'b1);
        check("clr_err_zero", 32'(bus8.err_count), 32'd0);
        check("clr_pulse", 32'(bus8.error_pulse), 32'd1);

        // Random counter stream with idles, glitches, jumps, clears and resets
        src = 8'($urandom);
        for (int i = 0; i < 600; i++) begin
            bit en, clr, rst;
            logic [7:0] d;
            rst = ($urandom_range(0, 149) == 0);
            clr = ($urandom_range(0, 29) == 0);
            en  = ($urandom_range(0, 7) != 0);
            d   = 8'($urandom);
            if (en) begin
                if ($urandom_range(0, 39) == 0) src = 8'($urandom);
                if ($urandom_range(0, 9) != 0) d = src;
                src = src + 8'd1;
            end
            cycle(rst, en, d, clr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
Receive-side partner of the 8-bit loadable up-counter. Samples a counter stream on `data_in` whenever `enable` is high and locks onto the +1 sequence. Once locked, it flags every value that breaks the sequence and keeps a saturating error count. Sits at the consuming end of any counter-driven bus, e.g. board loopback of `uo_out`, or on-chip self-test next to the counter instance.

Parameters:
- WIDTH, 8: width of the sampled count value.
- LOCK_COUNT, 4: consecutive in-sequence samples, seed included, needed to declare lock; legal range 2..15.
- LOSS_COUNT, 3: consecutive mismatches in LOCKED that drop lock back to HUNT; legal range 1..15.
- ERR_W, 8: width of the error counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  sample strobe; `data_in` is evaluated only on edges where enable=1
- data_in  input  WIDTH  observed counter value
- clr_err  input  1  synchronous clear of `err_count`
- locked  output  1  high while in LOCKED
- error_pulse  output  1  one-cycle flag: mismatch detected while LOCKED
- err_count  output  ERR_W  saturating mismatch count
- expected  output  WIDTH  value predicted for the next sample
- state  output  2  encoded FSM state, for debug

Behaviour:
- All outputs are registered and update on the sampling edge. Latency from sample to flag is one clock.
- Reset (reset=1 at posedge) wins over everything else. It sets:
  - state=HUNT, locked=0, error_pulse=0, err_count=0, expected=0
  - match_cnt=0, miss_cnt=0
- Reset mid-stream discards any lock already acquired.
- enable=0: all state, counters and `expected` hold; error_pulse=0.
- Arithmetic: `expected` increments modulo 2^WIDTH. 8'hFF followed by 8'h00 is a match.
- HUNT (enable=1):
  - expected<=data_in+1, match_cnt<=1, go to SYNC.
- SYNC (enable=1):
  - data_in==expected: expected++, match_cnt++.
  - If match_cnt+1==LOCK_COUNT: go to LOCKED, locked<=1, miss_cnt<=0.
  - Mismatch: re-seed with expected<=data_in+1, match_cnt<=1, stay in SYNC.
  - No errors are counted in SYNC.
- LOCKED (enable=1):
  - Match: expected++, miss_cnt<=0.
  - Mismatch:
    - error_pulse<=1 and err_count++ (saturates at all-ones).
    - expected++ (free-run; no re-seed), miss_cnt++.
    - If miss_cnt+1==LOSS_COUNT: go to HUNT, locked<=0, miss_cnt<=0, match_cnt<=0.
- clr_err=1: err_count<=0. Clear wins over a simultaneous increment; error_pulse still fires.
- State encoding: HUNT=0, SYNC=1, LOCKED=2. Value 3 is illegal and recovers to HUNT on the next edge.

Decomposition:
- Shared package `count_seq_pkg` holds:
  - the state enum (HUNT/SYNC/LOCKED)
  - default WIDTH / ERR_W constants
  - the encoding of the `state` port
- One natural sub-module, `sat_counter`: parameterised width, with inc, clr (clr priority) and saturation. Used for `err_count`; reusable for match_cnt/miss_cnt.
- FSM and comparator stay in the top.

Test Plan:
- Lock-on: reset, then enable=1 with data_in=C5,C6,C7,C8.
  - locked=1 at the edge sampling C8.
  - expected=C9 afterwards.
  - err_count=0, error_pulse never high.
- Wrap: locked stream FD,FE,FF,00,01.
  - No error_pulse, locked stays 1, expected=02.
- Single glitch: locked at expected=10, feed 10,11,55,13,14.
  - error_pulse high exactly one cycle, after 55.
  - err_count=1, locked stays 1.
- Loss of lock (LOSS_COUNT=3): locked at expected=20, feed 99,99,99.
  - err_count=3, locked drops at the third edge, state=HUNT.
  - Next sample 40 moves to SYNC with expected=41.
- Gaps and sync re-seed: samples C5, then enable=0 for 5 cycles with data_in toggling, then C6,C7,C8.
  - Lock still occurs; idle cycles are ignored.
  - In SYNC, C5,C6,07 re-seeds with expected=08, match_cnt=1.
- Reset/clear priority:
  - reset=1 while locked with err_count=5: all outputs 0 and state=HUNT the next cycle.
  - ERR_W=2 saturates at 3.
  - clr_err coincident with a mismatch gives err_count=0 and error_pulse=1.
